// File: rtl/addr_decoder.sv
// 3x3 window address generator for a 64x64 raster image: pixel counter, registered
// window centre, and combinational tap decode. Define ADDR_DECODER_BORDER_REPLICATE_EN
// to clamp out-of-image taps to the image edge instead of pointing them at PAD_ADDR.
module addr_decoder #(
    parameter logic [12:0] PAD_ADDR   = 13'd4096,
    parameter logic [12:0] LAST_COUNT = 13'd4097
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic [12:0] oAddrPixel,
    output logic        oWrite,
    output logic        oDone,
    output logic [5:0]  oBeginRow,
    output logic [5:0]  oBeginCol,
    output logic [12:0] oAddrP11,
    output logic [12:0] oAddrP12,
    output logic [12:0] oAddrP13,
    output logic [12:0] oAddrP21,
    output logic [12:0] oAddrP22,
    output logic [12:0] oAddrP23,
    output logic [12:0] oAddrP31,
    output logic [12:0] oAddrP32,
    output logic [12:0] oAddrP33
);

    localparam logic [12:0] NUM_PIXELS = 13'd4096;
    localparam logic [5:0]  EDGE_MAX   = 6'd63;

`ifdef ADDR_DECODER_BORDER_REPLICATE_EN
    localparam bit PAD_EN = 1'b0;
`else
    localparam bit PAD_EN = 1'b1;
`endif

    logic [12:0] cntPixel_p0;
    logic [5:0]  beginRow_p1;
    logic [5:0]  beginCol_p1;

    // Steps a row/column index by -1/0/+1 using edge compares only; an off-image step
    // leaves the index clamped at the edge and raises bit 6.
    function automatic logic [6:0] stepIdx(input logic [5:0] idx, input logic signed [1:0] d);
        logic [6:0] res;
        res = {1'b0, idx};
        if (d == -2'sd1) begin
            if (idx == 6'd0) res = {1'b1, idx};
            else             res = {1'b0, idx - 6'd1};
        end else if (d == 2'sd1) begin
            if (idx == EDGE_MAX) res = {1'b1, idx};
            else                 res = {1'b0, idx + 6'd1};
        end
        return res;
    endfunction

    function automatic logic [12:0] tapAddr(input logic [5:0] r, input logic [5:0] c,
                                            input logic signed [1:0] dr,
                                            input logic signed [1:0] dc);
        logic [6:0] rs;
        logic [6:0] cs;
        rs = stepIdx(r, dr);
        cs = stepIdx(c, dc);
        if (PAD_EN && (rs[6] || cs[6])) return PAD_ADDR;
        return {1'b0, rs[5:0], cs[5:0]};
    endfunction

    // Stage p0: raster pixel counter, saturating at LAST_COUNT
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cntPixel_p0 <= 13'd0;
        end else if (cntPixel_p0 != LAST_COUNT) begin
            cntPixel_p0 <= cntPixel_p0 + 13'd1;
        end
    end

    assign oAddrPixel = cntPixel_p0;
    assign oWrite     = (cntPixel_p0 != 13'd0) && (cntPixel_p0 <= NUM_PIXELS);
    assign oDone      = (cntPixel_p0 == LAST_COUNT);

    // Stage p1: window centre trails the counter by one pixel, frozen once the frame is swept
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            beginRow_p1 <= 6'd0;
            beginCol_p1 <= 6'd0;
        end else if (cntPixel_p0 < NUM_PIXELS) begin
            beginRow_p1 <= cntPixel_p0[11:6];
            beginCol_p1 <= cntPixel_p0[5:0];
        end
    end

    assign oBeginRow = beginRow_p1;
    assign oBeginCol = beginCol_p1;

    // Tap decode: combinational from the registered centre
    assign oAddrP11 = tapAddr(beginRow_p1, beginCol_p1, -2'sd1, -2'sd1);
    assign oAddrP12 = tapAddr(beginRow_p1, beginCol_p1, -2'sd1,  2'sd0);
    assign oAddrP13 = tapAddr(beginRow_p1, beginCol_p1, -2'sd1,  2'sd1);
    assign oAddrP21 = tapAddr(beginRow_p1, beginCol_p1,  2'sd0, -2'sd1);
    assign oAddrP22 = tapAddr(beginRow_p1, beginCol_p1,  2'sd0,  2'sd0);
    assign oAddrP23 = tapAddr(beginRow_p1, beginCol_p1,  2'sd0,  2'sd1);
    assign oAddrP31 = tapAddr(beginRow_p1, beginCol_p1,  2'sd1, -2'sd1);
    assign oAddrP32 = tapAddr(beginRow_p1, beginCol_p1,  2'sd1,  2'sd0);
    assign oAddrP33 = tapAddr(beginRow_p1, beginCol_p1,  2'sd1,  2'sd1);

endmodule

// File: tb/tb_addr_decoder.sv
// Self-checking bench for addr_decoder: full-frame sweep against a scoreboard,
// hand-computed window table, saturation hold, and asynchronous mid-frame reset.
module tb_addr_decoder;

    logic        iClk;
    logic        iRst;
    logic [12:0] oAddrPixel;
    logic        oWrite;
    logic        oDone;
    logic [5:0]  oBeginRow;
    logic [5:0]  oBeginCol;
    logic [12:0] oAddrP11, oAddrP12, oAddrP13;
    logic [12:0] oAddrP21, oAddrP22, oAddrP23;
    logic [12:0] oAddrP31, oAddrP32, oAddrP33;

    addr_decoder dut (
        .iClk(iClk), .iRst(iRst),
        .oAddrPixel(oAddrPixel), .oWrite(oWrite), .oDone(oDone),
        .oBeginRow(oBeginRow), .oBeginCol(oBeginCol),
        .oAddrP11(oAddrP11), .oAddrP12(oAddrP12), .oAddrP13(oAddrP13),
        .oAddrP21(oAddrP21), .oAddrP22(oAddrP22), .oAddrP23(oAddrP23),
        .oAddrP31(oAddrP31), .oAddrP32(oAddrP32), .oAddrP33(oAddrP33)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        int cnt;
        int row;
        int col;
        int wr;
        int dn;
    } exp_t;

    typedef struct {
        int k;
        int p11, p12, p13, p21, p22, p23, p31, p32, p33;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[8];
    int   nCmp  = 0;
    int   nFail = 0;
    int   expCnt = 0;

    task automatic chk(input string name, input int act, input int req);
        nCmp++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, req, $time);
        end
    endtask

    function automatic int expTap(input int row, input int col, input int dr, input int dc);
        int r;
        int c;
        r = row + dr;
        c = col + dc;
`ifdef ADDR_DECODER_BORDER_REPLICATE_EN
        if (r < 0) r = 0;
        if (r > 63) r = 63;
        if (c < 0) c = 0;
        if (c > 63) c = 63;
        return r * 64 + c;
`else
        if (r < 0 || r > 63 || c < 0 || c > 63) return 4096;
        return r * 64 + c;
`endif
    endfunction

    task automatic chkTaps(input string tag, input int row, input int col);
        chk({tag, " P11"}, oAddrP11, expTap(row, col, -1, -1));
        chk({tag, " P12"}, oAddrP12, expTap(row, col, -1,  0));
        chk({tag, " P13"}, oAddrP13, expTap(row, col, -1,  1));
        chk({tag, " P21"}, oAddrP21, expTap(row, col,  0, -1));
        chk({tag, " P22"}, oAddrP22, expTap(row, col,  0,  0));
        chk({tag, " P23"}, oAddrP23, expTap(row, col,  0,  1));
        chk({tag, " P31"}, oAddrP31, expTap(row, col,  1, -1));
        chk({tag, " P32"}, oAddrP32, expTap(row, col,  1,  0));
        chk({tag, " P33"}, oAddrP33, expTap(row, col,  1,  1));
    endtask

    task automatic chkVec(input vec_t v);
        chk("tbl P11", oAddrP11, v.p11);
        chk("tbl P12", oAddrP12, v.p12);
        chk("tbl P13", oAddrP13, v.p13);
        chk("tbl P21", oAddrP21, v.p21);
        chk("tbl P22", oAddrP22, v.p22);
        chk("tbl P23", oAddrP23, v.p23);
        chk("tbl P31", oAddrP31, v.p31);
        chk("tbl P32", oAddrP32, v.p32);
        chk("tbl P33", oAddrP33, v.p33);
    endtask

    function automatic exp_t mkExp(input int c);
        exp_t e;
        e.cnt = c;
        e.wr  = (c >= 1 && c <= 4096) ? 1 : 0;
        e.dn  = (c == 4097) ? 1 : 0;
        if (c == 0) begin
            e.row = 0;
            e.col = 0;
        end else if (c >= 4097) begin
            e.row = 63;
            e.col = 63;
        end else begin
            e.row = (c - 1) / 64;
            e.col = (c - 1) % 64;
        end
        return e;
    endfunction

    task automatic checkNow(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sbQ.pop_front();
        chk({tag, " addr"}, oAddrPixel, e.cnt);
        chk({tag, " write"}, oWrite, e.wr);
        chk({tag, " done"}, oDone, e.dn);
        chk({tag, " row"}, oBeginRow, e.row);
        chk({tag, " col"}, oBeginCol, e.col);
        chkTaps(tag, e.row, e.col);
    endtask

    task automatic step(input string tag);
        @(posedge iClk);
        expCnt = (expCnt >= 4097) ? 4097 : expCnt + 1;
        sbQ.push_back(mkExp(expCnt));
        #1;
        checkNow(tag);
`ifndef ADDR_DECODER_BORDER_REPLICATE_EN
        foreach (vecs[i]) begin
            if (expCnt == vecs[i].k + 1) chkVec(vecs[i]);
        end
`endif
    endtask

    initial begin
        vecs[0] = '{0,    4096, 4096, 4096, 4096,    0,    1, 4096,   64,   65};
        vecs[1] = '{660,   595,  596,  597,  659,  660,  661,  723,  724,  725};
        vecs[2] = '{4095, 4030, 4031, 4096, 4094, 4095, 4096, 4096, 4096, 4096};
        vecs[3] = '{5,    4096, 4096, 4096,    4,    5,    6,   68,   69,   70};
        vecs[4] = '{1984, 4096, 1920, 1921, 4096, 1984, 1985, 4096, 2048, 2049};
        vecs[5] = '{4032, 4096, 3968, 3969, 4096, 4032, 4033, 4096, 4096, 4096};
        vecs[6] = '{63,   4096, 4096, 4096,   62,   63, 4096,  126,  127, 4096};
        vecs[7] = '{1343, 1278, 1279, 4096, 1342, 1343, 4096, 1406, 1407, 4096};

        iRst = 1'b1;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        expCnt = 0;
        sbQ.push_back(mkExp(0));
        checkNow("reset");
`ifdef ADDR_DECODER_BORDER_REPLICATE_EN
        chk("rep00 P11", oAddrP11, 0);
        chk("rep00 P12", oAddrP12, 0);
        chk("rep00 P13", oAddrP13, 1);
        chk("rep00 P21", oAddrP21, 0);
        chk("rep00 P22", oAddrP22, 0);
        chk("rep00 P23", oAddrP23, 1);
        chk("rep00 P31", oAddrP31, 64);
        chk("rep00 P32", oAddrP32, 64);
        chk("rep00 P33", oAddrP33, 65);
`endif
        iRst = 1'b0;

        // Full frame plus saturation hold
        for (int n = 0; n < 5000; n++) step("sweep");

        // Restart and abort the frame at pixel 2000
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        iRst = 1'b0;
        expCnt = 0;
        for (int n = 0; n < 2000; n++) step("run2");
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        expCnt = 0;
        sbQ.push_back(mkExp(0));
        checkNow("midrst");
        #1;
        iRst = 1'b0;
        #1;
        sbQ.push_back(mkExp(0));
        checkNow("release");
        step("resume1");
        chk("resume1 addr literal", oAddrPixel, 1);
        step("resume2");
        chk("resume2 addr literal", oAddrPixel, 2);

        if (sbQ.size() != 0) chk("scoreboard drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
